iob_eth_tx_loader: RTL and testbench

Single-clock frame loader that sits directly upstream of the Ethernet core's CPU-side register bus.
- Accepts a payload byte stream with a last-byte marker.
- Waits until the core's transmitter reports ready, then writes each byte into the TX buffer.
- Zero-pads short frames to the minimum payload length.
- Programs `ETH_TX_NBYTES`, then strobes `ETH_SEND`.

This lets a streaming source transmit frames without CPU involvement.

---
 rtl/iob_eth_tx_loader_pkg.sv | 29 ++
 rtl/iob_eth_tx_loader.sv | 235 +++++++++++++++++++++++
 tb/tb_iob_eth_tx_loader.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iob_eth_tx_loader_pkg.sv
// -----------------------------------------------------------------------------
// iob_eth_tx_loader_pkg
//
// Shared definitions for the Ethernet TX frame loader.
//   - Register map of the Ethernet core's CPU-side bus (status, byte count,
//     send strobe) and the bus address width.
//   - Index width used for TX buffer byte addressing.
//   - data_addr(): maps a buffer byte index onto the core's data window.
//     Bit 11 set selects the TX buffer; bits 10:0 are the byte offset.
// -----------------------------------------------------------------------------
package iob_eth_tx_loader_pkg;

    // Core bus address width. Must hold {1'b1, idx[10:0]}.
    localparam int ETH_ADDR_W = 12;

    // Core register addresses (register window, bit 11 clear).
    localparam logic [ETH_ADDR_W-1:0] ETH_STATUS    = 12'd1;
    localparam logic [ETH_ADDR_W-1:0] ETH_SEND      = 12'd2;
    localparam logic [ETH_ADDR_W-1:0] ETH_TX_NBYTES = 12'd5;

    // Byte index width inside the TX buffer.
    localparam int IDX_W = 11;

    // TX buffer data window: top address bit set, byte offset below.
    function automatic logic [ETH_ADDR_W-1:0] data_addr(input logic [IDX_W-1:0] idx);
        return {1'b1, idx};
    endfunction

endpackage

// File: rtl/iob_eth_tx_loader.sv
// -----------------------------------------------------------------------------
// iob_eth_tx_loader
//
// Streams one payload frame into the Ethernet core's TX buffer and launches it.
// Polls ETH_STATUS until the transmitter is ready, writes every payload byte
// into the data window, zero-pads short frames up to MIN_BYTES, drops bytes
// past MAX_BYTES, then writes ETH_TX_NBYTES followed by ETH_SEND.
//
// Ports
//   clk, rst        single clock, synchronous active-high reset
//   s_valid/s_ready payload byte handshake; s_data byte, s_last end of frame
//   eth_valid       one-cycle core bus request
//   eth_wstrb       1 = write, 0 = read
//   eth_addr        core register / data address
//   eth_wdata       write data
//   eth_rdata       read data, sampled in the eth_ready cycle
//   eth_ready       core acknowledge (registered copy of eth_valid)
//   busy            high whenever the loader is not idle
//   sent            one-cycle pulse in the cycle ETH_SEND is acknowledged
//   truncated       pulses with sent when the frame exceeded MAX_BYTES
//
// Handshakes
//   Payload side: a byte moves on every rising edge where s_valid and s_ready
//   are both high; s_ready is only high in GET and does not depend on s_valid.
//   Core side: eth_valid is high for exactly one cycle per access, the core
//   answers with eth_ready one cycle later; eth_addr/eth_wstrb/eth_wdata are
//   held until then, and no new request is raised while one is outstanding.
// -----------------------------------------------------------------------------
module iob_eth_tx_loader
    import iob_eth_tx_loader_pkg::*;
#(
    parameter int MIN_BYTES = 46,
    parameter int MAX_BYTES = 1500,
    parameter int POLL_GAP  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic                  eth_valid,
    output logic                  eth_wstrb,
    output logic [ETH_ADDR_W-1:0] eth_addr,
    output logic [31:0]           eth_wdata,
    input  logic [31:0]           eth_rdata,
    input  logic                  eth_ready,
    output logic                  busy,
    output logic                  sent,
    output logic                  truncated
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_POLL = 3'd1,
        S_GET  = 3'd2,
        S_WRB  = 3'd3,
        S_PAD  = 3'd4,
        S_NB   = 3'd5,
        S_SND  = 3'd6
    } state_t;

    localparam logic [IDX_W-1:0] MIN_IDX = IDX_W'(MIN_BYTES);
    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(MAX_BYTES);

    // Poll-gap counter sized for POLL_GAP, at least one bit wide.
    localparam int GAP_W = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(POLL_GAP);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_inc;
    logic             trunc;
    logic             last_q;
    logic [GAP_W-1:0] gap_cnt;
    logic             gap_active;

    // Only the tx_ready bit of the status word is meaningful here.
    logic rdata_unused;
    assign rdata_unused = ^eth_rdata[31:1];

    assign idx_inc = idx + 11'd1;

    // Both are decoded straight from the state register.
    assign s_ready = (state == S_GET);
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            trunc      <= 1'b0;
            last_q     <= 1'b0;
            gap_cnt    <= '0;
            gap_active <= 1'b0;
            eth_valid  <= 1'b0;
            eth_wstrb  <= 1'b0;
            eth_addr   <= '0;
            eth_wdata  <= '0;
            sent       <= 1'b0;
            truncated  <= 1'b0;
        end else begin
            // Requests and status pulses are single-cycle by default.
            eth_valid <= 1'b0;
            sent      <= 1'b0;
            truncated <= 1'b0;

            case (state)
                S_IDLE: begin
                    // The first byte stays in the source until GET.
                    if (s_valid) begin
                        state      <= S_POLL;
                        gap_active <= 1'b0;
                        eth_valid  <= 1'b1;
                        eth_wstrb  <= 1'b0;
                        eth_addr   <= ETH_STATUS;
                        eth_wdata  <= '0;
                    end
                end

                S_POLL: begin
                    if (eth_ready) begin
                        if (eth_rdata[0]) begin
                            idx   <= '0;
                            state <= S_GET;
                        end else if (POLL_GAP == 0) begin
                            eth_valid <= 1'b1;
                        end else begin
                            gap_active <= 1'b1;
                            gap_cnt    <= GAP_INIT;
                        end
                    end else if (gap_active) begin
                        // Re-issue the read so it lands after POLL_GAP idle cycles.
                        if (gap_cnt == GAP_ONE) begin
                            gap_active <= 1'b0;
                            eth_valid  <= 1'b1;
                        end
                        gap_cnt <= gap_cnt - GAP_ONE;
                    end
                end

                S_GET: begin
                    if (s_valid) begin
                        last_q <= s_last;
                        if (idx < MAX_IDX) begin
                            state     <= S_WRB;
                            eth_valid <= 1'b1;
                            eth_wstrb <= 1'b1;
                            eth_addr  <= data_addr(idx);
                            eth_wdata <= {24'd0, s_data};
                        end else begin
                            // Buffer full: swallow the byte, remember the overflow.
                            trunc <= 1'b1;
                            if (s_last) begin
                                state     <= S_NB;
                                eth_valid <= 1'b1;
                                eth_wstrb <= 1'b1;
                                eth_addr  <= ETH_TX_NBYTES;
                                eth_wdata <= {21'd0, idx};
                            end
                        end
                    end
                end

                S_WRB: begin
                    if (eth_ready) begin
                        idx <= idx_inc;
                        if (!last_q) begin
                            state <= S_GET;
                        end else if (idx_inc >= MIN_IDX) begin
                            state     <= S_NB;
                            eth_valid <= 1'b1;
                            eth_wstrb <= 1'b1;
                            eth_addr  <= ETH_TX_NBYTES;
                            eth_wdata <= {21'd0, idx_inc};
                        end else begin
                            state     <= S_PAD;
                            eth_valid <= 1'b1;
                            eth_wstrb <= 1'b1;
                            eth_addr  <= data_addr(idx_inc);
                            eth_wdata <= '0;
                        end
                    end
                end

                S_PAD: begin
                    if (eth_ready) begin
                        idx <= idx_inc;
                        if (idx_inc >= MIN_IDX) begin
                            state     <= S_NB;
                            eth_valid <= 1'b1;
                            eth_wstrb <= 1'b1;
                            eth_addr  <= ETH_TX_NBYTES;
                            eth_wdata <= {21'd0, idx_inc};
                        end else begin
                            eth_valid <= 1'b1;
                            eth_wstrb <= 1'b1;
                            eth_addr  <= data_addr(idx_inc);
                            eth_wdata <= '0;
                        end
                    end
                end

                S_NB: begin
                    if (eth_ready) begin
                        state     <= S_SND;
                        eth_valid <= 1'b1;
                        eth_wstrb <= 1'b1;
                        eth_addr  <= ETH_SEND;
                        eth_wdata <= 32'd1;
                    end
                end

                S_SND: begin
                    // Pulses are raised during the request so they appear in
                    // the acknowledge cycle, the cycle the send is accepted.
                    if (eth_valid) begin
                        sent      <= 1'b1;
                        truncated <= trunc;
                        trunc     <= 1'b0;
                    end
                    if (eth_ready) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iob_eth_tx_loader.sv
// -----------------------------------------------------------------------------
// tb_iob_eth_tx_loader
//
// Bench for the Ethernet TX frame loader. A small core model acknowledges each
// request one cycle later and reports tx_ready in status bit 0. Frames are
// expanded into the list of bus writes they must produce; a negedge monitor
// checks every bus access, the sent/truncated pulses and the s_ready gating.
// -----------------------------------------------------------------------------
module tb_iob_eth_tx_loader;
  import iob_eth_tx_loader_pkg::*;

  localparam int MIN_B = 46;
  localparam int MAX_B = 1500;
  localparam int GAP   = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                  s_valid;
  logic [7:0]            s_data;
  logic                  s_last;
  logic                  s_ready;
  logic                  eth_valid;
  logic                  eth_wstrb;
  logic [ETH_ADDR_W-1:0] eth_addr;
  logic [31:0]           eth_wdata;
  logic [31:0]           eth_rdata;
  logic                  eth_ready = 1'b0;
  logic                  busy;
  logic                  sent;
  logic                  truncated;
  logic                  tx_ready;

  iob_eth_tx_loader #(.MIN_BYTES(MIN_B), .MAX_BYTES(MAX_B), .POLL_GAP(GAP)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .eth_valid(eth_valid), .eth_wstrb(eth_wstrb), .eth_addr(eth_addr),
    .eth_wdata(eth_wdata), .eth_rdata(eth_rdata), .eth_ready(eth_ready),
    .busy(busy), .sent(sent), .truncated(truncated)
  );

  // Core model: acknowledge one cycle after each request.
  always @(posedge clk) eth_ready <= eth_valid;
  assign eth_rdata = {31'd0, tx_ready};

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [43:0] exp_q[$];
  bit   exp_trunc = 1'b0;
  bit   ignore_wr = 1'b0;
  logic [7:0] mem [0:2047];
  int   cyc = 0;
  int   last_hs_cyc = 0;
  int   latency = 0;
  int   sent_cnt = 0;
  int   nb_last = 0;
  bit   trunc_last = 1'b0;
  int   rd_cyc_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor / compare ----------------
  initial begin
    bit prev_valid;
    bit prev_send_wr;
    logic [43:0] e;
    prev_valid   = 1'b0;
    prev_send_wr = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (eth_valid) begin
        check("no_overlap", prev_valid, 0);
        if (eth_wstrb) begin
          if (ignore_wr) begin
            check("abandoned_no_send", eth_addr == ETH_SEND, 0);
          end else if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", eth_addr, eth_wdata);
          end else begin
            e = exp_q.pop_front();
            check("write", {eth_addr, eth_wdata}, e);
          end
          if (eth_addr[11]) mem[eth_addr[10:0]] = eth_wdata[7:0];
          if (eth_addr == ETH_TX_NBYTES) nb_last = int'(eth_wdata);
        end else begin
          check("read_addr", eth_addr, ETH_STATUS);
          rd_cyc_q.push_back(cyc);
        end
      end
      if (!tx_ready) begin
        check("s_ready_gated", s_ready, 0);
        check("no_write_tx_busy", eth_valid && eth_wstrb, 0);
      end
      if (sent || prev_send_wr) check("sent_timing", sent, prev_send_wr);
      if (sent || truncated) check("trunc_pulse", {sent, truncated}, {1'b1, exp_trunc});
      if (sent) begin
        sent_cnt++;
        latency    = cyc - last_hs_cyc;
        trunc_last = truncated;
      end
      if (s_valid && s_ready && s_last) last_hs_cyc = cyc;
      prev_valid   = eth_valid;
      prev_send_wr = eth_valid && eth_wstrb && (eth_addr == ETH_SEND);
    end
  end

  // ---------------- driver tasks ----------------
  // Expands a frame into its expected bus writes, then streams it.
  // stop_after > 0 stops streaming after that many bytes.
  task automatic send_frame(input int len, input int stop_after, input bit toggle,
                            input bit expect_wr, input logic [7:0] base);
    int n;
    int nb;
    int wait_cnt;
    bit hs;
    logic [7:0] b;
    if (expect_wr) begin
      n = (len > MAX_B) ? MAX_B : len;
      for (int i = 0; i < n; i++) begin
        b = 8'(base + i);
        exp_q.push_back({12'(12'h800 + i), 24'd0, b});
      end
      for (int i = n; i < MIN_B; i++) exp_q.push_back({12'(12'h800 + i), 32'd0});
      nb = (n < MIN_B) ? MIN_B : n;
      exp_q.push_back({ETH_TX_NBYTES, 32'(nb)});
      exp_q.push_back({ETH_SEND, 32'd1});
      exp_trunc = (len > MAX_B);
    end
    for (int i = 0; i < len; i++) begin
      if (stop_after > 0 && i == stop_after) break;
      if (toggle && $urandom_range(0, 1) == 1) begin
        s_valid = 1'b0;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
      s_valid  = 1'b1;
      s_data   = 8'(base + i);
      s_last   = (i == len - 1);
      wait_cnt = 0;
      hs       = 1'b0;
      while (!hs && wait_cnt < 3000) begin
        @(negedge clk);
        if (s_ready) begin
          @(posedge clk);
          #1;
          hs = 1'b1;
        end else begin
          wait_cnt++;
        end
      end
      if (!hs) begin
        tests++;
        fails++;
        $display("FAIL byte_accept_timeout: byte %0d not accepted, expected within 3000 cycles", i);
        s_valid = 1'b0;
        s_last  = 1'b0;
        return;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_sent(input int prev_cnt);
    int n;
    n = 0;
    while (sent_cnt == prev_cnt && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (sent_cnt == prev_cnt) begin
      tests++;
      fails++;
      $display("FAIL sent_timeout: no sent pulse, expected within 600 cycles");
    end
    repeat (3) @(negedge clk);
    check("one_sent", sent_cnt - prev_cnt, 1);
    check("queue_drained", exp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int sc;
    int poll_snap[$];
    s_valid  = 1'b0;
    s_data   = 8'd0;
    s_last   = 1'b0;
    tx_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", s_ready, 0);
    check("rst_eth_valid", eth_valid, 0);
    check("rst_eth_wstrb", eth_wstrb, 0);
    check("rst_eth_addr", eth_addr, 0);
    check("rst_eth_wdata", eth_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_sent", sent, 0);
    check("rst_truncated", truncated, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // 60-byte frame 0x00..0x3B: no padding
    sc = sent_cnt;
    send_frame(60, 0, 1'b0, 1'b1, 8'h00);
    wait_sent(sc);
    check("f60_nbytes", nb_last, 60);
    check("f60_mem0", mem[0], 8'h00);
    check("f60_mem59", mem[59], 8'h3B);
    check("f60_latency", latency, 6);
    check("f60_trunc", trunc_last, 0);

    // 10-byte frame: 36 pad bytes
    sc = sent_cnt;
    send_frame(10, 0, 1'b0, 1'b1, 8'h00);
    wait_sent(sc);
    check("f10_nbytes", nb_last, 46);
    check("f10_mem9", mem[9], 8'h09);
    check("f10_mem10_pad", mem[10], 8'h00);
    check("f10_mem45_pad", mem[45], 8'h00);
    check("f10_latency", latency, 78);

    // 1503-byte frame: truncated to 1500
    sc = sent_cnt;
    send_frame(1503, 0, 1'b0, 1'b1, 8'h80);
    wait_sent(sc);
    check("f1503_nbytes", nb_last, 1500);
    check("f1503_trunc", trunc_last, 1);
    check("f1503_mem1499", mem[1499], 8'h5B);

    // tx_ready low for 20 cycles: polls only
    tx_ready = 1'b0;
    rd_cyc_q.delete();
    sc = sent_cnt;
    fork
      send_frame(46, 0, 1'b0, 1'b1, 8'h40);
      begin
        repeat (20) @(negedge clk);
        poll_snap = rd_cyc_q;
        tx_ready  = 1'b1;
      end
    join
    wait_sent(sc);
    check("poll_reads", poll_snap.size() >= 3, 1);
    for (int k = 1; k < poll_snap.size(); k++)
      check("poll_spacing", poll_snap[k] - poll_snap[k-1], GAP + 2);
    check("poll_nbytes", nb_last, 46);

    // Reset after 5 bytes: frame abandoned
    ignore_wr = 1'b1;
    sc = sent_cnt;
    send_frame(46, 5, 1'b0, 1'b0, 8'h10);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    repeat (10) @(negedge clk);
    check("midrst_no_send", sent_cnt - sc, 0);
    ignore_wr = 1'b0;
    #1;
    sc = sent_cnt;
    send_frame(46, 0, 1'b0, 1'b1, 8'hA0);
    wait_sent(sc);
    check("post_rst_nbytes", nb_last, 46);
    check("post_rst_mem5", mem[5], 8'hA5);
    check("post_rst_latency", latency, 6);

    // 100-byte frame with random s_valid gaps
    sc = sent_cnt;
    send_frame(100, 0, 1'b1, 1'b1, 8'h33);
    wait_sent(sc);
    check("f100_nbytes", nb_last, 100);
    check("f100_mem99", mem[99], 8'h96);
    check("f100_latency", latency, 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion before 2 ms");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
